rc_input_buffer: RTL and testbench
==================================

# rc_input_buffer

Per-input-port flit buffer sitting directly downstream of `route_comp` in the router datapath: it captures each routed flit together with its computed output direction, holds them in a FIFO until the virtual-channel/switch allocation stage accepts them, and returns batched credit flits to the upstream MGT neighbour as slots free. One instance per input direction (xpos, ypos, zpos, xneg, yneg, zneg). It also drives the `stall` input of its `route_comp`.

## Interface
Parameters:
- `FLIT_SIZE`, 256, flit width in bits
- `HEADER_LEN`, 2, width of flit type header (flit MSBs)
- `ROUTE_LEN`, 3, width of direction code from route computation
- `CREDIT_FLIT`, 2'b11, header value marking a credit flit
- `DEPTH`, 16, FIFO entries (power of two, >= 4)
- `CREDIT_BATCH`, 4, freed slots per credit flit (1..DEPTH)
- `CREDIT_TIMEOUT`, 32, idle cycles before flushing a partial batch (used only with macro)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flit_in`  in  FLIT_SIZE  flit from `route_comp` (`flit_after_RC`)
- `flit_in_valid`  in  1  flit_in qualifier
- `route_in`  in  ROUTE_LEN  direction from `route_comp` (`dir_out`)
- `stall`  out  1  FIFO full; holds `route_comp`
- `flit_out`  out  FLIT_SIZE  head flit to allocator
- `route_out`  out  ROUTE_LEN  head flit's direction
- `flit_out_valid`  out  1  head valid
- `flit_out_ready`  in  1  allocator accepts head this cycle
- `credit_out`  out  FLIT_SIZE  credit flit toward upstream MGT
- `credit_out_valid`  out  1  credit_out qualifier, one-cycle pulse
- `occupancy`  out  $clog2(DEPTH+1)  entries stored
- `overflow`  out  1  sticky: flit arrived while full

## Operation
- FIFO: storage of {flit, route}, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register.
- Enqueue when `flit_in_valid && !stall`. Dequeue when `flit_out_valid && flit_out_ready`.
- `stall` = (count == DEPTH), from registered count only. Flit arriving while `stall`=1 is dropped and `overflow` set (cleared only by `rst`), even if a dequeue happens the same cycle.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- `flit_out_valid` = (count != 0); `flit_out`/`route_out` show head entry; don't-care (hold last value) when empty.
- Credit flit format: bits [FLIT_SIZE-1 -: HEADER_LEN] = CREDIT_FLIT, bits [7:0] = credit count, all others 0.
- Credit accounting: `pending` register (width $clog2(DEPTH+1)); each cycle `pnext = pending + deq`. If `pnext >= CREDIT_BATCH`: register credit_out_valid=1 with count CREDIT_BATCH, `pending <= pnext - CREDIT_BATCH`; else `pending <= pnext`, credit_out_valid=0.
- Upstream never sends more than its credits, so overflow indicates a protocol error only.

## Timing
- Reset values: `stall`=0, `flit_out_valid`=0, `occupancy`=0, `overflow`=0, `credit_out_valid`=0, `credit_out`=0, `flit_out`/`route_out`=0, pointers/pending/timer=0.
- `rst` mid-operation: all contents discarded, no credits emitted for them; outputs take reset values the cycle after `rst` is sampled.
- Enqueue at edge t -> `flit_out_valid`=1 from t+1 (no same-cycle fall-through).
- Dequeue at edge t -> next entry (if any) on `flit_out` from t+1; full throughput one flit per cycle.
- Dequeue completing a batch at edge t -> `credit_out_valid`=1 during cycle t+1, exactly one cycle.
- `stall` deasserts the cycle after the dequeue that leaves count < DEPTH.

## Configuration
- `CREDIT_TIMEOUT_EN` defined: `timer` counts cycles with `pending != 0` and no credit emitted; reset to 0 on any emission or when `pending`==0. When timer reaches CREDIT_TIMEOUT-1 and batch rule did not fire, emit credit with count = `pnext`, `pending <= 0`. Batch rule has priority.
- Not defined: no timer logic; partial batches are held until completed.

## Test plan
- Reset, then 3 flits (route 1,2,3) with `flit_out_ready`=0 -> `occupancy`=3, `flit_out_valid`=1, head route 1, no credit.
- Fill 16 flits, send 17th with ready=0 -> `stall`=1 after 16th, 17th dropped, `overflow`=1, occupancy 16.
- Full FIFO, one cycle enqueue+dequeue -> enqueued flit dropped, occupancy 15, `overflow`=1.
- Stream 8 flits in, ready=1 continuously -> in-order output, one flit/cycle, exactly 2 credit pulses each count 4, one cycle after 4th and 8th dequeue.
- Dequeue 3 flits then idle (`CREDIT_TIMEOUT_EN`, timeout 32) -> single credit count 3 after 32 idle cycles; without macro no credit ever.
- Assert `rst` with 5 entries and pending=2 -> next cycle occupancy 0, valid 0, no credit pulse.

Source files
------------

// File: rtl/rc_input_buffer.sv
// Input-port flit FIFO storing {flit, route}; no fall-through: head and valid appear the cycle after enqueue; credit flits are registered.
// Backpressure: stall when full; flits arriving while full are dropped and latch overflow. Build option: CREDIT_TIMEOUT_EN flushes partial credit batches.
// Credits: one credit flit per CREDIT_BATCH dequeues.
module rc_input_buffer #(
    parameter int                   FLIT_SIZE      = 256,
    parameter int                   HEADER_LEN     = 2,
    parameter int                   ROUTE_LEN      = 3,
    parameter logic [HEADER_LEN-1:0] CREDIT_FLIT   = 2'b11,
    parameter int                   DEPTH          = 16,
    parameter int                   CREDIT_BATCH   = 4,
    parameter int                   CREDIT_TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_SIZE-1:0]         flit_in,
    input  logic                         flit_in_valid,
    input  logic [ROUTE_LEN-1:0]         route_in,
    output logic                         stall,
    output logic [FLIT_SIZE-1:0]         flit_out,
    output logic [ROUTE_LEN-1:0]         route_out,
    output logic                         flit_out_valid,
    input  logic                         flit_out_ready,
    output logic [FLIT_SIZE-1:0]         credit_out,
    output logic                         credit_out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = FLIT_SIZE + ROUTE_LEN;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_inc;
    logic [CW-1:0] count, count_nxt;
    logic [CW-1:0] pending, pending_nxt, pnext;
    logic [EW-1:0] head_q, head_nxt;
    logic          enq, deq;
    logic          fire;
    logic [7:0]    credit_cnt;
    logic [FLIT_SIZE-1:0] credit_flit;

    assign stall          = (count == CW'(DEPTH));
    assign flit_out_valid = (count != '0);
    assign occupancy      = count;
    assign enq            = flit_in_valid && !stall;
    assign deq            = flit_out_valid && flit_out_ready;
    assign rptr_inc       = rptr + AW'(1);
    assign {flit_out, route_out} = head_q;

    always_comb begin
        count_nxt = count;
        if (enq && !deq)
            count_nxt = count + CW'(1);
        else if (deq && !enq)
            count_nxt = count - CW'(1);
    end

    // Head register tracks the entry at rptr so the output is registered and holds when empty.
    always_comb begin
        head_nxt = head_q;
        if (deq) begin
            if (count > CW'(1))
                head_nxt = mem[rptr_inc];
            else if (enq)
                head_nxt = {flit_in, route_in};
        end else if (count == '0 && enq) begin
            head_nxt = {flit_in, route_in};
        end
    end

    assign pnext = pending + CW'(deq);

`ifdef CREDIT_TIMEOUT_EN
    localparam int TW = $clog2(CREDIT_TIMEOUT) + 1;
    logic [TW-1:0] timer;

    always_comb begin
        fire        = 1'b0;
        credit_cnt  = '0;
        pending_nxt = pnext;
        if (pnext >= CW'(CREDIT_BATCH)) begin
            fire        = 1'b1;
            credit_cnt  = 8'(CREDIT_BATCH);
            pending_nxt = pnext - CW'(CREDIT_BATCH);
        end else if (pending != '0 && timer == TW'(CREDIT_TIMEOUT - 1)) begin
            fire        = 1'b1;
            credit_cnt  = 8'(pnext);
            pending_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fire || pending == '0)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end
`else
    always_comb begin
        fire        = 1'b0;
        credit_cnt  = '0;
        pending_nxt = pnext;
        if (pnext >= CW'(CREDIT_BATCH)) begin
            fire        = 1'b1;
            credit_cnt  = 8'(CREDIT_BATCH);
            pending_nxt = pnext - CW'(CREDIT_BATCH);
        end
    end
`endif

    always_comb begin
        credit_flit = '0;
        credit_flit[FLIT_SIZE-1 -: HEADER_LEN] = CREDIT_FLIT;
        credit_flit[7:0] = credit_cnt;
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr] <= {flit_in, route_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            pending          <= '0;
            head_q           <= '0;
            overflow         <= 1'b0;
            credit_out_valid <= 1'b0;
            credit_out       <= '0;
        end else begin
            if (enq)
                wptr <= wptr + AW'(1);
            if (deq)
                rptr <= rptr_inc;
            count            <= count_nxt;
            pending          <= pending_nxt;
            head_q           <= head_nxt;
            credit_out_valid <= fire;
            credit_out       <= fire ? credit_flit : '0;
            if (flit_in_valid && stall)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rc_input_buffer.sv
// Self-checking bench for rc_input_buffer: directed scenarios plus a randomized run against a queue model.
module tb_rc_input_buffer;
    localparam int FS = 256;
    localparam int RL = 3;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [FS-1:0]    flit_in = '0;
    logic             flit_in_valid = 1'b0;
    logic [RL-1:0]    route_in = '0;
    logic             stall;
    logic [FS-1:0]    flit_out;
    logic [RL-1:0]    route_out;
    logic             flit_out_valid;
    logic             flit_out_ready = 1'b0;
    logic [FS-1:0]    credit_out;
    logic             credit_out_valid;
    logic [4:0]       occupancy;
    logic             overflow;

    rc_input_buffer dut (
        .clk(clk), .rst(rst),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid), .route_in(route_in),
        .stall(stall),
        .flit_out(flit_out), .route_out(route_out),
        .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
        .credit_out(credit_out), .credit_out_valid(credit_out_valid),
        .occupancy(occupancy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [FS+RL-1:0] mq[$];
    int  m_deqs;
    bit  m_ovf;
    bit  exp_cred;
    logic [FS-1:0] cred4;

    function automatic logic [FS-1:0] rand_flit();
        logic [FS-1:0] f;
        for (int i = 0; i < FS/32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic do_reset();
        flit_in_valid  = 1'b0;
        flit_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_deqs = 0;
        m_ovf = 0;
        exp_cred = 0;
    endtask

    // Drive one cycle and advance the model: full FIFO drops, every 4th dequeue earns a credit.
    task automatic step(input logic v, input logic [FS-1:0] f, input logic [RL-1:0] r, input logic rdy);
        bit full;
        bit dq;
        logic [FS+RL-1:0] popped;
        full = (mq.size() == DEPTH);
        dq   = (mq.size() != 0) && rdy;
        flit_in_valid  = v;
        flit_in        = f;
        route_in       = r;
        flit_out_ready = rdy;
        @(posedge clk);
        exp_cred = 0;
        if (dq) begin
            popped = mq.pop_front();
            m_deqs++;
            exp_cred = (m_deqs % 4 == 0);
        end
        if (v && !full) mq.push_back({f, r});
        if (v && full) m_ovf = 1;
        #1;
        flit_in_valid  = 1'b0;
        flit_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (flit_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", flit_out_valid); end
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (credit_out_valid !== 1'b0) begin failures++; $display("FAIL reset_cred_vld got=%b exp=0", credit_out_valid); end
        checks++; if (credit_out !== '0) begin failures++; $display("FAIL reset_cred got=%h exp=0", credit_out); end
        checks++; if ({flit_out, route_out} !== '0) begin failures++; $display("FAIL reset_head got=%h exp=0", {flit_out, route_out}); end
    endtask

    task automatic test_three();
        logic [FS-1:0] f0;
        do_reset();
        f0 = rand_flit();
        step(1'b1, f0, 3'd1, 1'b0);
        step(1'b1, rand_flit(), 3'd2, 1'b0);
        step(1'b1, rand_flit(), 3'd3, 1'b0);
        checks++; if (occupancy !== 5'd3) begin failures++; $display("FAIL three_occ got=%0d exp=3", occupancy); end
        checks++; if (flit_out_valid !== 1'b1) begin failures++; $display("FAIL three_valid got=%b exp=1", flit_out_valid); end
        checks++; if (route_out !== 3'd1) begin failures++; $display("FAIL three_route got=%0d exp=1", route_out); end
        checks++; if (flit_out !== f0) begin failures++; $display("FAIL three_flit got=%h exp=%h", flit_out, f0); end
        checks++; if (credit_out_valid !== 1'b0) begin failures++; $display("FAIL three_credit got=%b exp=0", credit_out_valid); end
    endtask

    task automatic test_fill_and_full_enq_deq();
        logic [FS+RL-1:0] second;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_flit(), RL'(i), 1'b0);
        second = mq[1];
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fill_stall got=%b exp=1", stall); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
        step(1'b1, rand_flit(), 3'd7, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
        checks++; if (occupancy !== 5'd16) begin failures++; $display("FAIL fill_occ got=%0d exp=16", occupancy); end
        step(1'b1, rand_flit(), 3'd6, 1'b1);
        checks++; if (occupancy !== 5'd15) begin failures++; $display("FAIL fulled_occ got=%0d exp=15", occupancy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fulled_ovf got=%b exp=1", overflow); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fulled_stall got=%b exp=0", stall); end
        checks++; if ({flit_out, route_out} !== second) begin failures++; $display("FAIL fulled_head got=%h exp=%h", {flit_out, route_out}, second); end
    endtask

    task automatic test_stream();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(c < 8, rand_flit(), RL'($urandom_range(0, 5)), 1'b1);
            checks++; if (occupancy !== ((c < 8) ? 5'd1 : 5'd0)) begin failures++; $display("FAIL stream_occ c=%0d got=%0d exp=%0d", c, occupancy, (c < 8) ? 1 : 0); end
            if (mq.size() != 0) begin
                checks++; if ({flit_out, route_out} !== mq[0]) begin failures++; $display("FAIL stream_head c=%0d got=%h exp=%h", c, {flit_out, route_out}, mq[0]); end
            end
            checks++; if (credit_out_valid !== (c == 4 || c == 8)) begin failures++; $display("FAIL stream_cred_vld c=%0d got=%b exp=%b", c, credit_out_valid, (c == 4 || c == 8)); end
            if (credit_out_valid === 1'b1) begin
                pulses++;
                checks++; if (credit_out !== cred4) begin failures++; $display("FAIL stream_cred c=%0d got=%h exp=%h", c, credit_out, cred4); end
            end
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL stream_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        logic [7:0] cnt = '0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rand_flit(), 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, '0, '0, 1'b0);
            if (credit_out_valid === 1'b1) begin pulses++; cnt = credit_out[7:0]; end
        end
`ifdef CREDIT_TIMEOUT_EN
        checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
        checks++; if (cnt !== 8'd3) begin failures++; $display("FAIL timeout_cnt got=%0d exp=3", cnt); end
`else
        checks++; if (pulses != 0) begin failures++; $display("FAIL timeout_pulses got=%0d exp=0", pulses); end
`endif
    endtask

    task automatic test_rst_mid();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, rand_flit(), 3'd4, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL rstmid_pre_occ got=%0d exp=5", occupancy); end
        do_reset();
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
        checks++; if (flit_out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", flit_out_valid); end
        checks++; if (credit_out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_cred got=%b exp=0", credit_out_valid); end
        // Stale pending credits would surface early here.
        for (int i = 0; i < 4; i++) step(1'b1, rand_flit(), 3'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b1);
            if (credit_out_valid === 1'b1) pulses++;
            checks++; if (credit_out_valid !== (i == 3)) begin failures++; $display("FAIL rstmid_pending i=%0d got=%b exp=%b", i, credit_out_valid, (i == 3)); end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, rand_flit(), RL'($urandom_range(0, 7)), ($urandom % 2) == 1);
            checks++; if (occupancy !== 5'(mq.size())) begin failures++; $display("FAIL rand_occ c=%0d got=%0d exp=%0d", c, occupancy, mq.size()); end
            checks++; if (stall !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall, mq.size() == DEPTH); end
            checks++; if (flit_out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%b", c, flit_out_valid); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
            if (mq.size() != 0) begin
                checks++; if ({flit_out, route_out} !== mq[0]) begin failures++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, {flit_out, route_out}, mq[0]); end
            end
`ifndef CREDIT_TIMEOUT_EN
            checks++; if (credit_out_valid !== exp_cred) begin failures++; $display("FAIL rand_cred c=%0d got=%b exp=%b", c, credit_out_valid, exp_cred); end
            if (exp_cred) begin
                checks++; if (credit_out !== cred4) begin failures++; $display("FAIL rand_cred_dat c=%0d got=%h exp=%h", c, credit_out, cred4); end
            end
`endif
        end
    endtask

    initial begin
        cred4 = '0;
        cred4[FS-1 -: 2] = 2'b11;
        cred4[7:0] = 8'd4;
        test_reset();
        test_three();
        test_fill_and_full_enq_deq();
        test_stream();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
